// File: rtl/csr_unit.sv
// csr_unit: execution stage for Zicsr instructions (CSRRW/CSRRS/CSRRC and
// their immediate forms) that sits in front of the counter CSR file.
//
// It accepts one decoded CSR op over a valid/ready handshake and checks it
// for legality. It reads the CSR, optionally writes it back one cycle later,
// and returns the old value with an illegal-instruction flag for rd
// writeback. It also merges pipeline retirements with its own and drives the
// CSR file's instret increment.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   op handshake (ready only while idle)
//   req_funct3            funct3 of the instruction
//   req_addr              CSR address
//   req_rs1_idx           rs1 field, also the 5-bit uimm
//   req_rs1_val           rs1 register value
//   req_rd_idx            destination register
//   resp_valid/resp_ready result handshake toward writeback
//   resp_rd_idx           latched rd
//   resp_rd_data          old CSR value (0 when illegal)
//   resp_illegal          illegal-instruction exception
//   retire_in             one-cycle pulse per non-CSR retirement
//   csr_addr              CSR file address (combinational read path)
//   csr_write             CSR file op: 00 none, 01 write, 10 set, 11 clear
//   csr_wdata             CSR file write data
//   csr_rdata             CSR file read data
//   inc_instret           CSR file instret increment strobe
module csr_unit #(
  parameter bit ALLOW_COUNTER_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_rd_idx,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd_idx,
  output logic [31:0] resp_rd_data,
  output logic        resp_illegal,
  input  logic        retire_in,
  output logic [11:0] csr_addr,
  output logic [1:0]  csr_write,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        inc_instret
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  funct3_r;
  logic [4:0]  rs1_idx_r;
  logic [31:0] rs1_val_r;
  logic [11:0] addr_r;
  logic [4:0]  rd_idx_r;
  logic [1:0]  csr_write_r;
  logic [31:0] csr_wdata_r;
  logic [31:0] rd_data_r;
  logic        illegal_r;
  logic        resp_valid_r;
  logic        req_ready_r;
  logic        inc_r;
  logic [1:0]  pending_r;

  logic [1:0]  op_code_s;
  logic        funct3_ok_s;
  logic        addr_ok_s;
  logic        do_write_s;
  logic        illegal_s;
  logic [31:0] operand_s;
  logic        accept_s;
  logic        fire_s;
  logic [1:0]  write_nxt_s;
  logic [31:0] wdata_nxt_s;
  logic [31:0] rd_data_nxt_s;
  logic        illegal_nxt_s;
  logic [1:0]  events_s;
  logic [2:0]  total_s;
  logic [2:0]  total_m1_s;
  logic [1:0]  pending_nxt_s;
  logic        inc_nxt_s;

  // Decode and legality of the latched op
  always_comb begin
    op_code_s   = 2'b00;
    funct3_ok_s = 1'b1;
    addr_ok_s   = 1'b0;
    // funct3[1:0] selects the operation; funct3[2] only selects the operand
    case (funct3_r[1:0])
      2'b01:   op_code_s = 2'b01;
      2'b10:   op_code_s = 2'b10;
      2'b11:   op_code_s = 2'b11;
      default: begin
        op_code_s   = 2'b00;
        funct3_ok_s = 1'b0;
      end
    endcase
    case (addr_r)
      12'hC00, 12'hC01, 12'hC02,
      12'hC80, 12'hC81, 12'hC82: addr_ok_s = 1'b1;
      default:                   addr_ok_s = 1'b0;
    endcase
    if (funct3_r[2]) begin
      operand_s = {27'd0, rs1_idx_r};
    end else begin
      operand_s = rs1_val_r;
    end
    // Set/clear with rs1 (or uimm) == 0 is a pure read and must not write
    do_write_s = (op_code_s == 2'b01) ||
                 (((op_code_s == 2'b10) || (op_code_s == 2'b11)) && (rs1_idx_r != 5'd0));
    illegal_s  = !funct3_ok_s || !addr_ok_s ||
                 (do_write_s && (ALLOW_COUNTER_WRITE == 1'b0) && (addr_r[11:10] == 2'b11));
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt_s   = state_r;
    accept_s      = 1'b0;
    fire_s        = 1'b0;
    write_nxt_s   = 2'b00;
    wdata_nxt_s   = csr_wdata_r;
    rd_data_nxt_s = rd_data_r;
    illegal_nxt_s = illegal_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s      = 1'b1;
          illegal_nxt_s = 1'b0;
          state_nxt_s   = EXEC;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      EXEC: begin
        illegal_nxt_s = illegal_s;
        if (illegal_s) begin
          rd_data_nxt_s = 32'd0;
          state_nxt_s   = RESP;
        end else if (do_write_s) begin
          rd_data_nxt_s = csr_rdata;
          write_nxt_s   = op_code_s;
          wdata_nxt_s   = operand_s;
          state_nxt_s   = COMMIT;
        end else begin
          rd_data_nxt_s = csr_rdata;
          state_nxt_s   = RESP;
        end
      end
      COMMIT: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          fire_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Retirement merge: at most one instret increment per cycle, backlog of up to 3
  always_comb begin
    events_s   = {1'b0, retire_in} + {1'b0, fire_s & ~illegal_r};
    total_s    = {1'b0, pending_r} + {1'b0, events_s};
    total_m1_s = total_s - 3'd1;
    if (total_s == 3'd0) begin
      inc_nxt_s     = 1'b0;
      pending_nxt_s = 2'd0;
    end else if (total_s > 3'd4) begin
      inc_nxt_s     = 1'b1;
      pending_nxt_s = 2'd3;
    end else begin
      inc_nxt_s     = 1'b1;
      pending_nxt_s = total_m1_s[1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched request fields, registered outputs and retire backlog
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_r     <= 3'd0;
      rs1_idx_r    <= 5'd0;
      rs1_val_r    <= 32'd0;
      addr_r       <= 12'd0;
      rd_idx_r     <= 5'd0;
      csr_write_r  <= 2'b00;
      csr_wdata_r  <= 32'd0;
      rd_data_r    <= 32'd0;
      illegal_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
      inc_r        <= 1'b0;
      pending_r    <= 2'd0;
    end else begin
      if (accept_s) begin
        funct3_r  <= req_funct3;
        rs1_idx_r <= req_rs1_idx;
        rs1_val_r <= req_rs1_val;
        addr_r    <= req_addr;
        rd_idx_r  <= req_rd_idx;
      end
      csr_write_r  <= write_nxt_s;
      csr_wdata_r  <= wdata_nxt_s;
      rd_data_r    <= rd_data_nxt_s;
      illegal_r    <= illegal_nxt_s;
      resp_valid_r <= (state_nxt_s == RESP);
      req_ready_r  <= (state_nxt_s == IDLE);
      inc_r        <= inc_nxt_s;
      pending_r    <= pending_nxt_s;
    end
  end

  // The latched address drives the CSR file directly, so the read in EXEC sees it
  assign csr_addr     = addr_r;
  assign csr_write    = csr_write_r;
  assign csr_wdata    = csr_wdata_r;
  assign req_ready    = req_ready_r;
  assign resp_valid   = resp_valid_r;
  assign resp_rd_idx  = rd_idx_r;
  assign resp_rd_data = rd_data_r;
  assign resp_illegal = illegal_r;
  assign inc_instret  = inc_r;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed self-checking bench for csr_unit.
// Two instances: dut (counter writes allowed, backed by a small counter CSR
// file model) and dut_nw (counter writes disallowed, constant read data).
// A select variable steers stimulus and observation to one of them.
module tb_csr_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rd_idx;
  logic        resp_ready;
  logic        retire_in;
  logic        sel_nw;

  logic        a_req_ready, a_resp_valid, a_resp_illegal, a_inc;
  logic [4:0]  a_rd_idx;
  logic [31:0] a_rd_data, a_wdata, a_rdata;
  logic [11:0] a_addr;
  logic [1:0]  a_write;

  logic        b_req_ready, b_resp_valid, b_resp_illegal, b_inc;
  logic [4:0]  b_rd_idx;
  logic [31:0] b_rd_data, b_wdata;
  logic [11:0] b_addr;
  logic [1:0]  b_write;

  logic        ob_req_ready, ob_resp_valid, ob_illegal, ob_inc;
  logic [4:0]  ob_rd_idx;
  logic [31:0] ob_rd_data, ob_wdata;
  logic [1:0]  ob_write;

  logic [63:0] m_cyc, m_ins, ld_val;
  logic        ld_cyc, ld_ins;

  int n_vec = 0;
  int n_err = 0;

  csr_unit #(.ALLOW_COUNTER_WRITE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel_nw), .req_ready(a_req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1_idx(req_rs1_idx),
    .req_rs1_val(req_rs1_val), .req_rd_idx(req_rd_idx),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rd_idx(a_rd_idx), .resp_rd_data(a_rd_data), .resp_illegal(a_resp_illegal),
    .retire_in(retire_in), .csr_addr(a_addr), .csr_write(a_write),
    .csr_wdata(a_wdata), .csr_rdata(a_rdata), .inc_instret(a_inc)
  );

  csr_unit #(.ALLOW_COUNTER_WRITE(1'b0)) dut_nw (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel_nw), .req_ready(b_req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1_idx(req_rs1_idx),
    .req_rs1_val(req_rs1_val), .req_rd_idx(req_rd_idx),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rd_idx(b_rd_idx), .resp_rd_data(b_rd_data), .resp_illegal(b_resp_illegal),
    .retire_in(retire_in), .csr_addr(b_addr), .csr_write(b_write),
    .csr_wdata(b_wdata), .csr_rdata(32'hDEAD_BEEF), .inc_instret(b_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ob_req_ready  = sel_nw ? b_req_ready    : a_req_ready;
    ob_resp_valid = sel_nw ? b_resp_valid   : a_resp_valid;
    ob_illegal    = sel_nw ? b_resp_illegal : a_resp_illegal;
    ob_inc        = sel_nw ? b_inc          : a_inc;
    ob_rd_idx     = sel_nw ? b_rd_idx       : a_rd_idx;
    ob_rd_data    = sel_nw ? b_rd_data      : a_rd_data;
    ob_wdata      = sel_nw ? b_wdata        : a_wdata;
    ob_write      = sel_nw ? b_write        : a_write;
  end

  // Counter CSR file model: combinational read, write/increment on the clock
  always_comb begin
    case (a_addr)
      12'hC00, 12'hC01: a_rdata = m_cyc[31:0];
      12'hC02:          a_rdata = m_ins[31:0];
      12'hC80, 12'hC81: a_rdata = m_cyc[63:32];
      12'hC82:          a_rdata = m_ins[63:32];
      default:          a_rdata = 32'hA5A5_A5A5;
    endcase
  end

  function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [1:0] op,
                                           input logic [31:0] d);
    case (op)
      2'b01:   return d;
      2'b10:   return old | d;
      2'b11:   return old & ~d;
      default: return old;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cyc <= 64'd0;
      m_ins <= 64'd0;
    end else begin
      if (ld_cyc) m_cyc <= ld_val;
      else if (a_write != 2'b00 && (a_addr == 12'hC00 || a_addr == 12'hC01))
        m_cyc <= {m_cyc[63:32], apply_op(m_cyc[31:0], a_write, a_wdata)};
      else if (a_write != 2'b00 && (a_addr == 12'hC80 || a_addr == 12'hC81))
        m_cyc <= {apply_op(m_cyc[63:32], a_write, a_wdata), m_cyc[31:0]};
      else m_cyc <= m_cyc + 64'd1;
      if (ld_ins) m_ins <= ld_val;
      else if (a_write != 2'b00 && a_addr == 12'hC02)
        m_ins <= {m_ins[63:32], apply_op(m_ins[31:0], a_write, a_wdata)};
      else if (a_write != 2'b00 && a_addr == 12'hC82)
        m_ins <= {apply_op(m_ins[63:32], a_write, a_wdata), m_ins[31:0]};
      else if (a_inc) m_ins <= m_ins + 64'd1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op (optionally preloading a model counter at the accept edge),
  // wait for resp_valid, and record latency and any CSR write seen on the way.
  task automatic do_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                       input logic [31:0] rs1v, input logic [4:0] rd,
                       input logic lc, input logic li, input logic [63:0] lv,
                       output int lat, output int wr_cnt,
                       output logic [1:0] wr_code, output logic [31:0] wr_data);
    req_funct3 = f3; req_addr = addr; req_rs1_idx = rs1; req_rs1_val = rs1v;
    req_rd_idx = rd; req_valid = 1'b1;
    ld_cyc = lc; ld_ins = li; ld_val = lv;
    lat = 0; wr_cnt = 0; wr_code = 2'b00; wr_data = 32'd0;
    while (!ob_resp_valid && lat < 8) begin
      @(posedge clk); #1;
      req_valid = 1'b0; ld_cyc = 1'b0; ld_ins = 1'b0;
      lat++;
      if (ob_write != 2'b00) begin
        wr_cnt++; wr_code = ob_write; wr_data = ob_wdata;
      end
    end
    check_vec("resp_valid_seen", {31'd0, ob_resp_valid}, 32'd1);
  endtask

  // Hold resp_ready low for some cycles (outputs must stay put), then handshake
  task automatic finish_resp(input int hold, input logic ret);
    logic [31:0] snap;
    snap = ob_rd_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_vec("hold_valid", {31'd0, ob_resp_valid}, 32'd1);
      check_vec("hold_ready", {31'd0, ob_req_ready}, 32'd0);
      check_vec("hold_data", ob_rd_data, snap);
    end
    resp_ready = 1'b1; retire_in = ret;
    @(posedge clk); #1;
    resp_ready = 1'b0; retire_in = 1'b0;
    check_vec("post_hs_valid", {31'd0, ob_resp_valid}, 32'd0);
    check_vec("post_hs_ready", {31'd0, ob_req_ready}, 32'd1);
  endtask

  int          lat, wc;
  logic [1:0]  wcode;
  logic [31:0] wdat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_addr = 12'd0;
    req_rs1_idx = 5'd0; req_rs1_val = 32'd0; req_rd_idx = 5'd0;
    resp_ready = 1'b0; retire_in = 1'b0; sel_nw = 1'b0;
    ld_cyc = 1'b0; ld_ins = 1'b0; ld_val = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    check_vec("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    check_vec("rst_illegal", {31'd0, a_resp_illegal}, 32'd0);
    check_vec("rst_rd_data", a_rd_data, 32'd0);
    check_vec("rst_rd_idx", {27'd0, a_rd_idx}, 32'd0);
    check_vec("rst_csr_addr", {20'd0, a_addr}, 32'd0);
    check_vec("rst_csr_write", {30'd0, a_write}, 32'd0);
    check_vec("rst_csr_wdata", a_wdata, 32'd0);
    check_vec("rst_inc", {31'd0, a_inc}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // CSRRS x0 on cycle, counter preset to 100 for the EXEC read
    do_op(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, 64'd100, lat, wc, wcode, wdat);
    check_vec("rs_x0_lat", lat, 32'd2);
    check_vec("rs_x0_data", ob_rd_data, 32'd100);
    check_vec("rs_x0_wr", wc, 32'd0);
    check_vec("rs_x0_ill", {31'd0, ob_illegal}, 32'd0);
    check_vec("rs_x0_rd", {27'd0, ob_rd_idx}, 32'd1);
    // Stall 3 cycles, then own retire collides with retire_in
    finish_resp(3, 1'b1);
    check_vec("coll_inc0", {31'd0, ob_inc}, 32'd1);
    @(posedge clk); #1;
    check_vec("coll_inc1", {31'd0, ob_inc}, 32'd1);
    @(posedge clk); #1;
    check_vec("coll_inc2", {31'd0, ob_inc}, 32'd0);

    // CSRRW instret (preset 7) with 5, then read back 5 + own retire
    do_op(3'b001, 12'hC02, 5'd7, 32'd5, 5'd2, 1'b0, 1'b1, 64'd7, lat, wc, wcode, wdat);
    check_vec("rw_lat", lat, 32'd3);
    check_vec("rw_data", ob_rd_data, 32'd7);
    check_vec("rw_wcnt", wc, 32'd1);
    check_vec("rw_code", {30'd0, wcode}, 32'd1);
    check_vec("rw_wdata", wdat, 32'd5);
    finish_resp(0, 1'b0);
    check_vec("rw_inc", {31'd0, ob_inc}, 32'd1);
    do_op(3'b010, 12'hC02, 5'd0, 32'd0, 5'd3, 1'b0, 1'b0, 64'd0, lat, wc, wcode, wdat);
    check_vec("rw_readback", ob_rd_data, 32'd6);
    finish_resp(0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // CSRRCI cycleh uimm 3 with cycleh preset to 0xF, then read back 0xC
    do_op(3'b111, 12'hC80, 5'd3, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0, 64'h0000_000F_0000_0000,
          lat, wc, wcode, wdat);
    check_vec("rci_lat", lat, 32'd3);
    check_vec("rci_data", ob_rd_data, 32'h0000_000F);
    check_vec("rci_code", {30'd0, wcode}, 32'd3);
    check_vec("rci_wdata", wdat, 32'd3);
    finish_resp(0, 1'b0);
    do_op(3'b010, 12'hC80, 5'd0, 32'd0, 5'd4, 1'b0, 1'b0, 64'd0, lat, wc, wcode, wdat);
    check_vec("rci_readback", ob_rd_data, 32'h0000_000C);
    finish_resp(0, 1'b0);

    // CSRRSI cycle uimm 9: set with immediate operand
    do_op(3'b110, 12'hC00, 5'd9, 32'hFFFF_0000, 5'd5, 1'b1, 1'b0, 64'd50, lat, wc, wcode, wdat);
    check_vec("rsi_data", ob_rd_data, 32'd50);
    check_vec("rsi_code", {30'd0, wcode}, 32'd2);
    check_vec("rsi_wdata", wdat, 32'd9);
    finish_resp(0, 1'b0);

    // CSRRC with rs1 = x0 on time: read only
    do_op(3'b011, 12'hC01, 5'd0, 32'hFFFF_FFFF, 5'd6, 1'b1, 1'b0, 64'd20, lat, wc, wcode, wdat);
    check_vec("rc_x0_lat", lat, 32'd2);
    check_vec("rc_x0_data", ob_rd_data, 32'd20);
    check_vec("rc_x0_wr", wc, 32'd0);
    finish_resp(0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Illegal address 0x300
    do_op(3'b010, 12'h300, 5'd0, 32'd0, 5'd7, 1'b0, 1'b0, 64'd0, lat, wc, wcode, wdat);
    check_vec("badaddr_lat", lat, 32'd2);
    check_vec("badaddr_ill", {31'd0, ob_illegal}, 32'd1);
    check_vec("badaddr_data", ob_rd_data, 32'd0);
    check_vec("badaddr_wr", wc, 32'd0);
    finish_resp(0, 1'b0);
    check_vec("badaddr_inc", {31'd0, ob_inc}, 32'd0);

    // Illegal funct3 100
    do_op(3'b100, 12'hC00, 5'd1, 32'd1, 5'd8, 1'b0, 1'b0, 64'd0, lat, wc, wcode, wdat);
    check_vec("badf3_lat", lat, 32'd2);
    check_vec("badf3_ill", {31'd0, ob_illegal}, 32'd1);
    check_vec("badf3_data", ob_rd_data, 32'd0);
    check_vec("badf3_wr", wc, 32'd0);
    finish_resp(0, 1'b0);

    // Counter writes disallowed: CSRRCI cycleh is illegal, plain read is fine
    sel_nw = 1'b1;
    #1;
    do_op(3'b111, 12'hC80, 5'd3, 32'd0, 5'd9, 1'b0, 1'b0, 64'd0, lat, wc, wcode, wdat);
    check_vec("nw_lat", lat, 32'd2);
    check_vec("nw_ill", {31'd0, ob_illegal}, 32'd1);
    check_vec("nw_data", ob_rd_data, 32'd0);
    check_vec("nw_wr", wc, 32'd0);
    finish_resp(0, 1'b0);
    check_vec("nw_inc0", {31'd0, ob_inc}, 32'd0);
    @(posedge clk); #1;
    check_vec("nw_inc1", {31'd0, ob_inc}, 32'd0);
    do_op(3'b010, 12'hC00, 5'd0, 32'd0, 5'd10, 1'b0, 1'b0, 64'd0, lat, wc, wcode, wdat);
    check_vec("nw_rd_ill", {31'd0, ob_illegal}, 32'd0);
    check_vec("nw_rd_data", ob_rd_data, 32'hDEAD_BEEF);
    finish_resp(0, 1'b0);
    sel_nw = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while in COMMIT abandons the op
    req_funct3 = 3'b001; req_addr = 12'hC02; req_rs1_idx = 5'd1;
    req_rs1_val = 32'h55; req_rd_idx = 5'd11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_vec("mid_commit_wr", {30'd0, a_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_vec("mid_rst_wr", {30'd0, a_write}, 32'd0);
    check_vec("mid_rst_valid", {31'd0, a_resp_valid}, 32'd0);
    check_vec("mid_rst_ready", {31'd0, a_req_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_vec("after_rst_wr", {30'd0, a_write}, 32'd0);
    check_vec("after_rst_valid", {31'd0, a_resp_valid}, 32'd0);
    check_vec("after_rst_inc", {31'd0, a_inc}, 32'd0);
    @(posedge clk); #1;
    check_vec("after_rst_inc2", {31'd0, a_inc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
